// File: rtl/pio_pattern_sequencer_if.sv
// Control-slave and PIO-master signal bundle for pio_pattern_sequencer.
// The slave modport is the sequencer's view; the master modport is the host/bench view.
interface pio_pattern_sequencer_if;
    logic [1:0]  ctl_address;
    logic        ctl_chipselect;
    logic        ctl_write_n;
    logic [31:0] ctl_writedata;
    logic [31:0] ctl_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;

    modport slave (
        input  ctl_address, ctl_chipselect, ctl_write_n, ctl_writedata,
        output ctl_readdata, m_address, m_chipselect, m_write_n, m_writedata
    );

    modport master (
        output ctl_address, ctl_chipselect, ctl_write_n, ctl_writedata,
        input  ctl_readdata, m_address, m_chipselect, m_write_n, m_writedata
    );
endinterface

// File: rtl/pio_pattern_sequencer.sv
// Plays a stored byte pattern into PIO register 0 at a programmable interval.
// Optional done interrupt port enabled by defining PIO_SEQ_IRQ_EN.
module pio_pattern_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    pio_pattern_sequencer_if.slave   bus
`ifdef PIO_SEQ_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_mem [DEPTH];
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_interval, r_cnt;
    logic               r_loop, r_irq_en, r_done, w_done_nxt;
    logic               w_done_set, w_done_clr;
    logic               r_m_cs, r_m_wn;
    logic [31:0]        r_m_wd, w_m_wd_nxt;
    logic               w_m_wr_nxt;
    logic               w_wr, w_wr_ctl, w_wr_pat, w_pat_we;
    logic               w_start, w_stop, w_clear;
    logic               w_busy, w_full, w_len_nz, w_last, w_cnt_zero;
    logic               w_unused;

    // Host command decode
    assign w_wr       = bus.ctl_chipselect & ~bus.ctl_write_n;
    assign w_wr_ctl   = w_wr && (bus.ctl_address == 2'd0);
    assign w_wr_pat   = w_wr && (bus.ctl_address == 2'd3);
    assign w_start    = w_wr_ctl & bus.ctl_writedata[0];
    assign w_stop     = w_wr_ctl & bus.ctl_writedata[2];
    assign w_clear    = w_wr_ctl & bus.ctl_writedata[3];
    assign w_busy     = (r_state != S_IDLE);
    assign w_full     = (r_wr_ptr == PTR_W'(DEPTH));
    assign w_len_nz   = (r_wr_ptr != '0);
    assign w_last     = ((PTR_W'(r_idx) + PTR_W'(1)) >= r_wr_ptr);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_pat_we   = w_wr_pat & ~w_full & ~w_busy;
    assign w_unused   = ^bus.ctl_writedata;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start && w_len_nz) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_stop ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (w_stop)                        w_state_nxt = S_IDLE;
                else if (w_cnt_zero && (!w_last || r_loop)) w_state_nxt = S_WRITE;
                else if (w_cnt_zero)               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next index, DONE updates and the next bus beat (outputs are registered)
    always_comb begin
        w_idx_nxt  = r_idx;
        w_done_set = 1'b0;
        w_done_clr = w_wr && (bus.ctl_address == 2'd1) && bus.ctl_writedata[1];
        case (r_state)
            S_IDLE: begin
                if (w_start && w_len_nz) begin
                    w_idx_nxt  = '0;
                    w_done_clr = 1'b1;
                end
            end
            S_WAIT: begin
                if (!w_stop && w_cnt_zero) begin
                    if (!w_last)     w_idx_nxt = IDX_W'(r_idx + IDX_W'(1));
                    else if (r_loop) w_idx_nxt = '0;
                    else             w_done_set = 1'b1;
                end
            end
            default: ;
        endcase
        w_done_nxt = w_done_set | (r_done & ~w_done_clr);
        w_m_wr_nxt = (w_state_nxt == S_WRITE);
        w_m_wd_nxt = w_m_wr_nxt ? {24'd0, r_mem[w_idx_nxt]} : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_wr_ptr   <= '0;
            r_interval <= '0;
            r_cnt      <= '0;
            r_loop     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_m_cs     <= 1'b0;
            r_m_wn     <= 1'b1;
            r_m_wd     <= '0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_done <= w_done_nxt;
            r_m_cs <= w_m_wr_nxt;
            r_m_wn <= ~w_m_wr_nxt;
            r_m_wd <= w_m_wd_nxt;
            // Interval is sampled on each WRITE so mid-playback updates apply to the next beat
            if (r_state == S_WRITE)                r_cnt <= r_interval;
            else if (r_state == S_WAIT && !w_cnt_zero) r_cnt <= r_cnt - CNT_W'(1);
            if (w_wr_ctl) begin
                r_loop   <= bus.ctl_writedata[1];
                r_irq_en <= bus.ctl_writedata[4];
            end
            if (w_wr && (bus.ctl_address == 2'd2))
                r_interval <= bus.ctl_writedata[CNT_W-1:0];
            if (w_clear && !w_busy) r_wr_ptr <= '0;
            else if (w_pat_we)      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_pat_we) r_mem[r_wr_ptr[IDX_W-1:0]] <= bus.ctl_writedata[7:0];
    end

`ifdef PIO_SEQ_IRQ_EN
    logic w_irq_en_nxt;
    assign w_irq_en_nxt = w_wr_ctl ? bus.ctl_writedata[4] : r_irq_en;

    // Tracks DONE & IRQ_EN with no extra lag so a W1C drops irq on the next cycle
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= w_done_nxt & w_irq_en_nxt;
    end
`endif

    always_comb begin
        bus.ctl_readdata = '0;
        case (bus.ctl_address)
            2'd0:    bus.ctl_readdata = {27'd0, r_irq_en, 2'b00, r_loop, 1'b0};
            2'd1:    bus.ctl_readdata = {8'd0, 8'(r_wr_ptr), 8'(r_idx), 5'd0, w_full, r_done, w_busy};
            2'd2:    bus.ctl_readdata = 32'(r_interval);
            default: bus.ctl_readdata = '0;
        endcase
    end

    assign bus.m_address    = 2'd0;
    assign bus.m_chipselect = r_m_cs;
    assign bus.m_write_n    = r_m_wn;
    assign bus.m_writedata  = r_m_wd;

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Scoreboard bench for pio_pattern_sequencer: expected PIO writes (data + cycle) are queued
// as playback is started and matched by a bus monitor; irq checks need PIO_SEQ_IRQ_EN.
module tb_pio_pattern_sequencer;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pio_pattern_sequencer_if bus();
`ifdef PIO_SEQ_IRQ_EN
    logic irq;
`endif

    pio_pattern_sequencer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PIO_SEQ_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: every write pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.m_chipselect === 1'b1 && bus.m_write_n === 1'b0) begin
            n_pulses++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL pio_write_unexpected: got data=%h at cycle %0d, required no write", bus.m_writedata, cyc);
            end else begin
                mon_e = q.pop_front();
                if (bus.m_writedata !== mon_e.data || cyc != mon_e.cyc || bus.m_address !== 2'd0) begin
                    failures++;
                    $display("FAIL pio_write: got data=%h addr=%0d cycle=%0d, required data=%h addr=0 cycle=%0d",
                             bus.m_writedata, bus.m_address, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int n);
        @(posedge clk); #1;
        n = cyc;
        bus.ctl_address    = a;
        bus.ctl_writedata  = d;
        bus.ctl_chipselect = 1'b1;
        bus.ctl_write_n    = 1'b0;
        @(posedge clk); #1;
        bus.ctl_chipselect = 1'b0;
        bus.ctl_write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.ctl_address = a;
        #1;
        d = bus.ctl_readdata;
    endtask

    task automatic load(input logic [7:0] pat [$]);
        int n;
        wr(2'd0, 32'h8, n);
        foreach (pat[i]) wr(2'd3, {24'd0, pat[i]}, n);
    endtask

    task automatic wait_q_empty(output logic to);
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0) break;
            @(negedge clk); #1;
        end
        to = (q.size() != 0);
    endtask

    task automatic wait_idle(output int c, output logic to);
        logic [31:0] s;
        to = 1'b1;
        c  = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rd(2'd1, s);
            if (s[0] == 1'b0) begin
                c  = cyc;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if (bus.m_chipselect !== 1'b0 || bus.m_write_n !== 1'b1 || bus.m_writedata !== 32'd0 || bus.m_address !== 2'd0) begin
            failures++;
            $display("FAIL reset_bus: got cs=%b wn=%b wd=%h addr=%0d, required cs=0 wn=1 wd=0 addr=0",
                     bus.m_chipselect, bus.m_write_n, bus.m_writedata, bus.m_address);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'd0) begin
                failures++;
                $display("FAIL reset_reg%0d: got %h, required 00000000", a, d);
            end
        end
`ifdef PIO_SEQ_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b, required 0", irq);
        end
`endif
    endtask

    task automatic test_one_shot();
        logic [7:0]  pat [$];
        logic [31:0] s;
        int n, c, dummy;
        logic to;
        pat = '{8'h11, 8'h22, 8'h33};
        load(pat);
        wr(2'd2, 32'd3, dummy);
        wr(2'd0, 32'h1, n);
        q.push_back('{32'h11, n + 1});
        q.push_back('{32'h22, n + 6});
        q.push_back('{32'h33, n + 11});
        wait_idle(c, to);
        checks++;
        if (to || c != n + 16) begin
            failures++;
            $display("FAIL one_shot_done_cycle: got cycle %0d (timeout=%b), required %0d", c, to, n + 16);
        end
        rd(2'd1, s);
        checks++;
        if (s[2:0] !== 3'b010 || s[23:16] !== 8'd3 || s[15:8] !== 8'd2) begin
            failures++;
            $display("FAIL one_shot_status: got %h, required 00030202", s);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL one_shot_writes: %0d writes missing, required 0", q.size());
        end
        wr(2'd1, 32'h2, dummy);
        rd(2'd1, s);
        checks++;
        if (s[1] !== 1'b0) begin
            failures++;
            $display("FAIL done_w1c: got DONE=%b, required 0", s[1]);
        end
    endtask

    task automatic test_loop_stop();
        logic [7:0]  pat [$];
        logic [31:0] s;
        int n, p, dummy;
        logic to;
        pat = '{8'hA5, 8'h5A};
        load(pat);
        wr(2'd2, 32'd0, dummy);
        wr(2'd0, 32'h3, n);
        for (int k = 0; k < 6; k++)
            q.push_back('{(k % 2 == 0) ? 32'hA5 : 32'h5A, n + 1 + 2 * k});
        wait_q_empty(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL loop_writes: timeout with %0d writes missing, required 0", q.size());
        end
        p = n_pulses;
        wr(2'd0, 32'h4, dummy);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (n_pulses != p) begin
            failures++;
            $display("FAIL stop_no_writes: got %0d extra writes, required 0", n_pulses - p);
        end
        rd(2'd1, s);
        checks++;
        if (s[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL stop_status: got DONE/BUSY=%b, required 00", s[1:0]);
        end
    endtask

    task automatic test_full_clear();
        logic [31:0] s;
        int n, c, p, dummy;
        logic to;
        wr(2'd0, 32'h8, dummy);
        for (int i = 0; i <= DEPTH; i++)
            wr(2'd3, (i == DEPTH) ? 32'hEE : 32'(i + 1), dummy);
        rd(2'd1, s);
        checks++;
        if (s[2] !== 1'b1 || s[23:16] !== 8'(DEPTH)) begin
            failures++;
            $display("FAIL full_status: got FULL=%b LENGTH=%0d, required FULL=1 LENGTH=%0d", s[2], s[23:16], DEPTH);
        end
        wr(2'd2, 32'd0, dummy);
        wr(2'd0, 32'h1, n);
        for (int i = 0; i < DEPTH; i++) q.push_back('{32'(i + 1), n + 1 + 2 * i});
        wait_idle(c, to);
        checks++;
        if (to || q.size() != 0) begin
            failures++;
            $display("FAIL full_playback: timeout=%b, %0d writes missing, required 0", to, q.size());
        end
        wr(2'd0, 32'h8, dummy);
        rd(2'd1, s);
        checks++;
        if (s[23:16] !== 8'd0 || s[2] !== 1'b0) begin
            failures++;
            $display("FAIL clear_status: got LENGTH=%0d FULL=%b, required 0 0", s[23:16], s[2]);
        end
        p = n_pulses;
        wr(2'd0, 32'h1, dummy);
        repeat (5) @(posedge clk);
        #1;
        rd(2'd1, s);
        checks++;
        if (s[0] !== 1'b0 || n_pulses != p) begin
            failures++;
            $display("FAIL start_empty: got BUSY=%b writes=%0d, required BUSY=0 writes=0", s[0], n_pulses - p);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  pat [$];
        logic [31:0] s;
        int n, c, dummy;
        logic to;
        pat = '{8'h10, 8'h20, 8'h30};
        load(pat);
        wr(2'd2, 32'd4, dummy);
        wr(2'd0, 32'h1, n);
        q.push_back('{32'h10, n + 1});
        q.push_back('{32'h20, n + 7});
        q.push_back('{32'h30, n + 13});
        for (int i = 0; i < 50; i++) begin
            if (q.size() < 3) break;
            @(negedge clk); #1;
        end
        wr(2'd0, 32'h1, dummy);
        wr(2'd3, 32'h99, dummy);
        wr(2'd0, 32'h8, dummy);
        wait_idle(c, to);
        checks++;
        if (to || c != n + 19 || q.size() != 0) begin
            failures++;
            $display("FAIL busy_ignore_done: got cycle %0d timeout=%b missing=%0d, required cycle %0d", c, to, q.size(), n + 19);
        end
        rd(2'd1, s);
        checks++;
        if (s[23:16] !== 8'd3 || s[1] !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore_status: got LENGTH=%0d DONE=%b, required 3 1", s[23:16], s[1]);
        end
    endtask

    task automatic test_irq();
        logic [31:0] s;
        logic [7:0]  pat [$];
        int n, c, dummy;
        logic to;
        wr(2'd0, 32'h12, dummy);
        rd(2'd0, s);
        checks++;
        if (s !== 32'h12) begin
            failures++;
            $display("FAIL control_readback: got %h, required 00000012", s);
        end
        pat = '{8'h7E};
        load(pat);
        wr(2'd2, 32'd0, dummy);
        wr(2'd0, 32'h11, n);
        q.push_back('{32'h7E, n + 1});
        wait_idle(c, to);
        checks++;
        if (to || c != n + 3) begin
            failures++;
            $display("FAIL irq_done_cycle: got cycle %0d timeout=%b, required %0d", c, to, n + 3);
        end
`ifdef PIO_SEQ_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_set: got %b, required 1", irq);
        end
        wr(2'd1, 32'h2, dummy);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear: got %b, required 0", irq);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0]  pat [$];
        logic [31:0] s;
        int n, p, dummy;
        logic to;
        pat = '{8'h01, 8'h02, 8'h03, 8'h04};
        load(pat);
        wr(2'd2, 32'd5, dummy);
        wr(2'd0, 32'h1, n);
        q.push_back('{32'h01, n + 1});
        q.push_back('{32'h02, n + 8});
        q.push_back('{32'h03, n + 15});
        wait_q_empty(to);
        @(posedge clk); #1;
        rd(2'd1, s);
        checks++;
        if (to || s[0] !== 1'b1 || s[15:8] !== 8'd2) begin
            failures++;
            $display("FAIL pre_reset_state: got BUSY=%b idx=%0d timeout=%b, required BUSY=1 idx=2", s[0], s[15:8], to);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.m_chipselect !== 1'b0 || bus.m_write_n !== 1'b1 || bus.m_writedata !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_bus: got cs=%b wn=%b wd=%h, required cs=0 wn=1 wd=0",
                     bus.m_chipselect, bus.m_write_n, bus.m_writedata);
        end
        reset = 1'b0;
        rd(2'd1, s);
        checks++;
        if (s !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_status: got %h, required 00000000", s);
        end
        rd(2'd2, s);
        checks++;
        if (s !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_interval: got %h, required 00000000", s);
        end
        p = n_pulses;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_pulses != p) begin
            failures++;
            $display("FAIL post_reset_writes: got %0d writes, required 0", n_pulses - p);
        end
    endtask

    initial begin
        bus.ctl_address    = 2'd0;
        bus.ctl_chipselect = 1'b0;
        bus.ctl_write_n    = 1'b1;
        bus.ctl_writedata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_one_shot();
        test_loop_stop();
        test_full_clear();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
